// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine change path:
// coin unit values (in 50-won units), denomination codes and dispenser states.
package vend_pkg;

  localparam logic [6:0] DEN50   = 7'd1;
  localparam logic [6:0] DEN100  = 7'd2;
  localparam logic [6:0] DEN500  = 7'd10;
  localparam logic [6:0] DEN1000 = 7'd20;

  typedef enum logic [1:0] {
    CODE50   = 2'd0,
    CODE100  = 2'd1,
    CODE500  = 2'd2,
    CODE1000 = 2'd3
  } den_code_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  function automatic logic [6:0] den_value(input den_code_e code);
    case (code)
      CODE50:   den_value = DEN50;
      CODE100:  den_value = DEN100;
      CODE500:  den_value = DEN500;
      CODE1000: den_value = DEN1000;
      default:  den_value = DEN50;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: largest coin that fits the remaining balance
// and is still in stock.
module coin_select
  import vend_pkg::*;
#(
  parameter int INV_W = 6
) (
  input  logic [6:0]       remaining,
  input  logic [INV_W-1:0] inv50,
  input  logic [INV_W-1:0] inv100,
  input  logic [INV_W-1:0] inv500,
  input  logic [INV_W-1:0] inv1000,
  output logic             found,
  output den_code_e        code,
  output logic [6:0]       value
);

  localparam logic [INV_W-1:0] EMPTY = {INV_W{1'b0}};

  // Priority order 1000 > 500 > 100 > 50; an empty slot falls through.
  always_comb begin
    found = 1'b1;
    code  = CODE50;
    if (remaining >= DEN1000 && inv1000 != EMPTY) begin
      code = CODE1000;
    end else if (remaining >= DEN500 && inv500 != EMPTY) begin
      code = CODE500;
    end else if (remaining >= DEN100 && inv100 != EMPTY) begin
      code = CODE100;
    end else if (remaining >= DEN50 && inv50 != EMPTY) begin
      code = CODE50;
    end else begin
      found = 1'b0;
    end
  end

  assign value = den_value(code);

endmodule

// File: rtl/change_dispenser.sv
// Pays out a customer balance as single-cycle coin pulses, tracking a
// per-denomination inventory that the operator refills while idle.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int INV_W      = 6,
  parameter int INIT_COUNT = 20,
  parameter int GAP        = 1
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Return,
  input  logic [6:0]       Amount,
  input  logic             Refill,
  input  logic [1:0]       Refill_sel,
  input  logic [INV_W-1:0] Refill_count,
  output logic             Return50,
  output logic             Return100,
  output logic             Return500,
  output logic             Return1000,
  output logic             Busy,
  output logic             Done,
  output logic [6:0]       Shortfall,
  output logic [INV_W-1:0] Inv50,
  output logic [INV_W-1:0] Inv100,
  output logic [INV_W-1:0] Inv500,
  output logic [INV_W-1:0] Inv1000
);

  localparam logic [INV_W-1:0] INIT_INV = INV_W'(INIT_COUNT);
  localparam logic [INV_W-1:0] INV_MAX  = {INV_W{1'b1}};
  localparam logic [INV_W-1:0] INV_ONE  = {{(INV_W-1){1'b0}}, 1'b1};
  localparam int               GCW      = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GCW-1:0]   GAP_LAST = GCW'(GAP - 1);
  localparam bit               NO_GAP   = (GAP == 0);

  state_e           state_q, state_d;
  logic [6:0]       remaining_q, remaining_d;
  den_code_e        code_q, code_d;
  logic [6:0]       val_q, val_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [3:0]       ret_q, ret_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [6:0]       shortfall_q, shortfall_d;
  logic [INV_W-1:0] inv_q [4];
  logic [INV_W-1:0] inv_d [4];

  logic             sel_found;
  den_code_e        sel_code;
  logic [6:0]       sel_value;
  logic [INV_W:0]   refill_sum;
  logic [INV_W-1:0] refill_val;

  coin_select #(.INV_W(INV_W)) u_coin_select (
    .remaining (remaining_q),
    .inv50     (inv_q[CODE50]),
    .inv100    (inv_q[CODE100]),
    .inv500    (inv_q[CODE500]),
    .inv1000   (inv_q[CODE1000]),
    .found     (sel_found),
    .code      (sel_code),
    .value     (sel_value)
  );

  // Saturating refill value for the selected slot.
  always_comb begin
    refill_sum = {1'b0, inv_q[Refill_sel]} + {1'b0, Refill_count};
    if (refill_sum[INV_W]) begin
      refill_val = INV_MAX;
    end else begin
      refill_val = refill_sum[INV_W-1:0];
    end
  end

  // Next-state and datapath updates; coin pulses and Done are set one edge
  // early so they appear registered in the PULSE and FINISH cycles.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    code_d      = code_q;
    val_d       = val_q;
    gap_cnt_d   = gap_cnt_q;
    ret_d       = 4'b0000;
    busy_d      = busy_q;
    done_d      = 1'b0;
    shortfall_d = shortfall_q;
    inv_d       = inv_q;
    case (state_q)
      ST_IDLE: begin
        if (Return) begin
          remaining_d = Amount;
          shortfall_d = 7'd0;
          busy_d      = 1'b1;
          state_d     = ST_SELECT;
        end else if (Refill) begin
          inv_d[Refill_sel] = refill_val;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (remaining_q == 7'd0) begin
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else if (sel_found) begin
          code_d          = sel_code;
          val_d           = sel_value;
          ret_d[sel_code] = 1'b1;
          state_d         = ST_PULSE;
        end else begin
          shortfall_d = remaining_q;
          done_d      = 1'b1;
          state_d     = ST_FINISH;
        end
      end
      ST_PULSE: begin
        remaining_d   = remaining_q - val_q;
        inv_d[code_q] = inv_q[code_q] - INV_ONE;
        gap_cnt_d     = {GCW{1'b0}};
        if (NO_GAP) begin
          state_d = ST_SELECT;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_SELECT;
        end else begin
          gap_cnt_d = gap_cnt_q + {{(GCW-1){1'b0}}, 1'b1};
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= 7'd0;
      code_q      <= CODE50;
      val_q       <= 7'd0;
      gap_cnt_q   <= {GCW{1'b0}};
      ret_q       <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shortfall_q <= 7'd0;
      for (int i = 0; i < 4; i++) begin
        inv_q[i] <= INIT_INV;
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      code_q      <= code_d;
      val_q       <= val_d;
      gap_cnt_q   <= gap_cnt_d;
      ret_q       <= ret_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      shortfall_q <= shortfall_d;
      for (int i = 0; i < 4; i++) begin
        inv_q[i] <= inv_d[i];
      end
    end
  end

  assign Return50   = ret_q[CODE50];
  assign Return100  = ret_q[CODE100];
  assign Return500  = ret_q[CODE500];
  assign Return1000 = ret_q[CODE1000];
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Shortfall  = shortfall_q;
  assign Inv50      = inv_q[CODE50];
  assign Inv100     = inv_q[CODE100];
  assign Inv500     = inv_q[CODE500];
  assign Inv1000    = inv_q[CODE1000];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues the
// expected coin pulses and Done event with their cycle stamps.
module tb_change_dispenser;

  localparam int INV_W = 6;
  localparam int INIT  = 20;
  localparam int GAP   = 1;
  localparam int MAXI  = (1 << INV_W) - 1;

  logic             CLK = 1'b0;
  logic             Reset_n;
  logic             Return;
  logic [6:0]       Amount;
  logic             Refill;
  logic [1:0]       Refill_sel;
  logic [INV_W-1:0] Refill_count;
  logic             Return50, Return100, Return500, Return1000;
  logic             Busy, Done;
  logic [6:0]       Shortfall;
  logic [INV_W-1:0] Inv50, Inv100, Inv500, Inv1000;

  change_dispenser #(.INV_W(INV_W), .INIT_COUNT(INIT), .GAP(GAP)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Return(Return), .Amount(Amount),
    .Refill(Refill), .Refill_sel(Refill_sel), .Refill_count(Refill_count),
    .Return50(Return50), .Return100(Return100), .Return500(Return500),
    .Return1000(Return1000), .Busy(Busy), .Done(Done), .Shortfall(Shortfall),
    .Inv50(Inv50), .Inv100(Inv100), .Inv500(Inv500), .Inv1000(Inv1000)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit is_done;
    int code;
    int cyc;
    int sf;
  } exp_t;

  exp_t exp_q[$];
  int   m_inv [4];
  int   unit  [4] = '{1, 2, 10, 20};
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int inv_obs(input int d);
    case (d)
      0: return int'(Inv50);
      1: return int'(Inv100);
      2: return int'(Inv500);
      3: return int'(Inv1000);
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) m_inv[d] = INIT;
    exp_q.delete();
  endtask

  // Greedy model: queue expected pulses and the Done event for an accept at cycle a.
  task automatic model_payout(input int amt, input int a);
    int   rem = amt;
    int   n   = 0;
    int   pick;
    exp_t e;
    forever begin
      pick = -1;
      for (int d = 3; d >= 0; d--) begin
        if (pick < 0 && unit[d] <= rem && m_inv[d] > 0) pick = d;
      end
      if (pick < 0) break;
      e = '{is_done: 1'b0, code: pick, cyc: a + 1 + n * (2 + GAP), sf: 0};
      exp_q.push_back(e);
      m_inv[pick]--;
      rem -= unit[pick];
      n++;
    end
    e = '{is_done: 1'b1, code: 0, cyc: a + n * (2 + GAP) + 1, sf: rem};
    exp_q.push_back(e);
  endtask

  // Output monitor: pops the scoreboard on every coin pulse and Done.
  logic [3:0] mon_ret;
  int         mon_code;
  exp_t       mon_e;
  always @(negedge CLK) begin
    if (Reset_n) begin
      mon_ret = {Return1000, Return500, Return100, Return50};
      if (mon_ret != 4'b0000) begin
        chk_eq("onehot", $countones(mon_ret), 1);
        mon_code = 0;
        for (int d = 0; d < 4; d++) if (mon_ret[d]) mon_code = d;
        if (exp_q.size() == 0) begin
          chk_eq("extra_pulse", mon_code, -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("pulse_kind", int'(mon_e.is_done), 0);
          chk_eq("pulse_code", mon_code, mon_e.code);
          chk_eq("pulse_cyc", cyc, mon_e.cyc);
        end
      end
      if (Done) begin
        if (exp_q.size() == 0) begin
          chk_eq("extra_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("done_kind", int'(mon_e.is_done), 1);
          chk_eq("done_cyc", cyc, mon_e.cyc);
          chk_eq("done_busy", int'(Busy), 1);
          chk_eq("shortfall", int'(Shortfall), mon_e.sf);
          for (int d = 0; d < 4; d++) chk_eq("done_inv", inv_obs(d), m_inv[d]);
        end
      end
    end
  end

  task automatic start_payout(input int amt, input bit with_refill);
    int a;
    @(negedge CLK);
    Return = 1'b1;
    Amount = 7'(amt);
    if (with_refill) begin
      Refill       = 1'b1;
      Refill_sel   = 2'd0;
      Refill_count = 6'd7;
    end
    @(posedge CLK);
    #1;
    a = cyc;
    model_payout(amt, a);
    @(negedge CLK);
    Return = 1'b0;
    Refill = 1'b0;
    chk_eq("busy_after_accept", int'(Busy), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      chk_eq("timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge CLK);
  endtask

  task automatic payout(input int amt);
    start_payout(amt, 1'b0);
    wait_idle();
  endtask

  task automatic do_refill(input int sel, input int cnt);
    @(negedge CLK);
    Refill       = 1'b1;
    Refill_sel   = 2'(sel);
    Refill_count = INV_W'(cnt);
    @(negedge CLK);
    Refill = 1'b0;
    m_inv[sel] = (m_inv[sel] + cnt > MAXI) ? MAXI : m_inv[sel] + cnt;
    chk_eq("refill_inv", inv_obs(sel), m_inv[sel]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed %0d expected %0d", cyc, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0; Return = 1'b0; Amount = 7'd0;
    Refill = 1'b0; Refill_sel = 2'd0; Refill_count = 6'd0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk_eq("rst_returns", int'({Return1000, Return500, Return100, Return50}), 0);
    chk_eq("rst_busy", int'(Busy), 0);
    chk_eq("rst_done", int'(Done), 0);
    chk_eq("rst_shortfall", int'(Shortfall), 0);
    for (int d = 0; d < 4; d++) chk_eq("rst_inv", inv_obs(d), INIT);
    Reset_n = 1'b1;
    repeat (2) @(negedge CLK);

    // Amount 37: 1000, 500, 100 x3, 50
    payout(37);
    chk_eq("t37_inv1000", int'(Inv1000), 19);
    chk_eq("t37_inv500", int'(Inv500), 19);
    chk_eq("t37_inv100", int'(Inv100), 17);
    chk_eq("t37_inv50", int'(Inv50), 19);
    chk_eq("t37_shortfall", int'(Shortfall), 0);
    chk_eq("t37_idle_busy", int'(Busy), 0);

    // Exhaust 500s, then 10 units must come out as five 100s
    while (m_inv[2] > 0) payout(10);
    chk_eq("drain_inv500", int'(Inv500), 0);
    payout(10);
    chk_eq("sub_inv100", int'(Inv100), 12);
    chk_eq("sub_shortfall", int'(Shortfall), 0);

    // Leave only two 50s, then ask for 5 units
    while (m_inv[3] > 0) payout(20);
    while (m_inv[1] > 0) payout(2);
    while (m_inv[0] > 2) payout(1);
    payout(5);
    chk_eq("short_shortfall", int'(Shortfall), 3);
    chk_eq("short_inv50", int'(Inv50), 0);

    // Fresh inventory; saturating refill
    @(negedge CLK);
    Reset_n = 1'b0;
    @(negedge CLK);
    Reset_n = 1'b1;
    model_reset();
    do_refill(3, 50);
    chk_eq("sat_inv1000", int'(Inv1000), MAXI);

    // Return+Refill together, then Refill while busy: both dropped
    start_payout(1, 1'b1);
    Refill = 1'b1; Refill_sel = 2'd2; Refill_count = 6'd9;
    @(negedge CLK);
    Refill = 1'b0;
    wait_idle();
    chk_eq("busy_refill_inv500", int'(Inv500), 20);
    chk_eq("busy_refill_inv50", int'(Inv50), 19);

    // Return re-asserted mid-payout is ignored
    start_payout(37, 1'b0);
    repeat (3) @(negedge CLK);
    Return = 1'b1; Amount = 7'd3;
    repeat (2) @(negedge CLK);
    Return = 1'b0;
    wait_idle();
    repeat (10) @(negedge CLK);
    chk_eq("reassert_busy", int'(Busy), 0);

    // Amount 0: Done only, no pulses
    payout(0);
    chk_eq("zero_shortfall", int'(Shortfall), 0);

    // Reset in the middle of the first PULSE cycle
    start_payout(37, 1'b0);
    @(posedge CLK);
    #2;
    chk_eq("pre_rst_pulse", int'(Return1000), 1);
    Reset_n = 1'b0;
    #1;
    chk_eq("rst_mid_ret1000", int'(Return1000), 0);
    chk_eq("rst_mid_busy", int'(Busy), 0);
    chk_eq("rst_mid_inv1000", int'(Inv1000), INIT);
    model_reset();
    @(negedge CLK);
    Reset_n = 1'b1;
    payout(37);
    chk_eq("after_rst_inv1000", int'(Inv1000), 19);
    chk_eq("after_rst_inv100", int'(Inv100), 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream stage of the vending-machine controller (UUT). On a Return request it takes the customer balance and pays it out greedily as single-cycle coin pulses on Return1000/500/100/50. It tracks a per-denomination coin inventory, substitutes smaller coins when a larger one is exhausted, and reports any amount it cannot pay. The operator refills the inventory through the Manage path.

Parameters:
INV_W, 6, width of each inventory counter (saturates at 2^INV_W-1)
INIT_COUNT, 20, inventory of every denomination after reset
GAP, 1, idle cycles between consecutive coin pulses (0 allowed)

Ports:
CLK  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Return  input  1  payout request; sampled only in IDLE
Amount  input  7  balance to pay, in units of 50 won (0..127)
Refill  input  1  one-cycle inventory refill strobe
Refill_sel  input  2  denomination to refill: 0=50, 1=100, 2=500, 3=1000
Refill_count  input  INV_W  coins added on Refill
Return50/Return100/Return500/Return1000  output  1 each  coin-eject pulses
Busy  output  1  high from the cycle after accept through FINISH
Done  output  1  one-cycle completion pulse
Shortfall  output  7  unpaid units from the last payout
Inv50/Inv100/Inv500/Inv1000  output  INV_W each  current inventory

Behaviour:
- Reset (async, Reset_n=0): state IDLE; all Return* 0; Busy 0; Done 0; Shortfall 0; every Inv* = INIT_COUNT; remaining 0.
- Unit values: 50→1, 100→2, 500→10, 1000→20. Remaining register is 7 bits; subtraction never underflows because a coin is chosen only if its value <= remaining.
- IDLE: when Return=1 at an edge, latch Amount into remaining, clear Shortfall, go to SELECT. Refill is accepted only in IDLE; in any other state it is ignored. Refill adds to the selected Inv* with saturation at 2^INV_W-1. Return and Refill in the same IDLE cycle: Return wins and Refill is dropped.
- SELECT (1 cycle): pick the largest denomination with value <= remaining and Inv > 0.
  - Found: go to PULSE.
  - remaining==0: go to FINISH.
  - None found and remaining>0: Shortfall <= remaining, then go to FINISH.
- PULSE (1 cycle): the chosen Return* output is registered high for exactly this cycle. remaining -= value; chosen Inv -= 1. Then go to GAP, or to SELECT if GAP=0.
- GAP: hold all Return* low for GAP cycles, then go to SELECT.
- FINISH (1 cycle): Done=1, Busy=1, then go to IDLE. Shortfall holds until the next accepted Return.
- At most one Return* is high in any cycle.
- Return while Busy: ignored, no queuing.
- Timing for a payout of N coins with no shortfall: Done is high in the cycle N*(2+GAP)+1 cycles after the accept edge. The first coin pulse is in the second cycle after the accept edge.
- Amount=0: no pulses; Done is high in the second cycle after accept.
- Reset_n low mid-payout: outputs drop immediately; inventory returns to INIT_COUNT.

Decomposition:
- Shared package vend_pkg:
  - denomination unit constants DEN50=1, DEN100=2, DEN500=10, DEN1000=20
  - 2-bit denomination code
  - state enum IDLE/SELECT/PULSE/GAP/FINISH
- One natural sub-module: coin_select, a combinational priority picker. Inputs: remaining, four inventories. Outputs: found flag, code, unit value.
- FSM, counters and output registers stay in change_dispenser.

Test Plan:
- Reset, Amount=37, Return pulse, GAP=1 -> pulses in order 1000, 500, 100, 100, 100, 50, spaced 3 cycles apart. Done 19 cycles after accept; Shortfall=0; Inv1000=19, Inv500=19, Inv100=17, Inv50=19.
- Drain Inv500 to 0 (Refill cannot subtract, so use repeated payouts of Amount=10), then Amount=10 -> five Return100 pulses, no Return500; Shortfall=0.
- Inventories 1000/500/100 at 0 and Inv50=2, Amount=5 -> two Return50 pulses, Shortfall=3, Inv50=0, Done asserted.
- Refill in IDLE with Refill_sel=3, Refill_count=50 on Inv1000=20 -> Inv1000=63 (saturates). Refill during Busy -> no change.
- Return re-asserted mid-payout -> ignored; exactly one Done. Amount=0 -> Done two cycles after accept, no pulses.
- Reset_n pulsed low during the PULSE cycle -> Return* low asynchronously; state IDLE; all Inv*=20; next Return works normally.
